multi_freq_meter: RTL and testbench

Multi-channel frequency meter: counts edges on NUM_CH asynchronous input signals over a common, parametrised gate window and publishes one count per channel at the end of each window. Each result comes with a one-cycle valid strobe and a per-channel overflow flag. Inputs are synchronised on chip, and the edge type to count is selectable at run time. The block sits between the external signal pins and the display/readout logic, which consumes `freq` on `valid`.

---
 rtl/multi_freq_meter.sv | 119 +++++++++++
 tb/tb_multi_freq_meter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_freq_meter.sv
// Multi-channel edge-counting frequency meter sharing one gate window.
// Per channel: 2-flop synchroniser, history flop, selectable edge, saturating counter.
module multi_freq_meter #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 24,
  parameter int GATE_CYCLES = 100000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [NUM_CH-1:0]       infreq,
  output logic [NUM_CH*CNT_W-1:0] freq,
  output logic [NUM_CH-1:0]       ovf,
  output logic                    valid,
  output logic                    busy
);
  localparam int                GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]     G_LAST    = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [1:0]        MODE_FALL = 2'b01;
  localparam logic [1:0]        MODE_BOTH = 2'b10;

  logic [NUM_CH-1:0]       sync1_q, sync2_q, hist_q;
  logic [1:0]              mode_q;
  logic [GW-1:0]           gcnt_q, gcnt_d;
  logic [CNT_W-1:0]        acc_q [NUM_CH];
  logic [CNT_W-1:0]        acc_d [NUM_CH];
  logic [NUM_CH-1:0]       iovf_q, iovf_d;
  logic [NUM_CH*CNT_W-1:0] freq_q, freq_d;
  logic [NUM_CH-1:0]       ovf_q, ovf_d;
  logic                    valid_q, valid_d, busy_q;
  logic [NUM_CH-1:0]       rise, fall, ev;
  logic                    run, last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
    if (inc && (a != CNT_MAX)) return a + CNT_W'(1);
    return a;
  endfunction

  function automatic logic sat_hit(input logic [CNT_W-1:0] a, input logic inc);
    return inc && (a == CNT_MAX);
  endfunction

  // Reserved mode 11 falls through to rising-edge counting.
  function automatic logic sel_edge(input logic [1:0] m, input logic r, input logic f);
    case (m)
      MODE_FALL: return f;
      MODE_BOTH: return r | f;
      default:   return r;
    endcase
  endfunction

  assign rise = sync2_q & ~hist_q;
  assign fall = ~sync2_q & hist_q;

  // A mode change discards the running window; the window restarts next cycle.
  assign run  = en && (mode == mode_q);
  assign last = run && (gcnt_q == G_LAST);

  always_comb begin
    ev      = '0;
    gcnt_d  = '0;
    iovf_d  = '0;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      ev[i]    = sel_edge(mode_q, rise[i], fall[i]);
      acc_d[i] = '0;
    end
    if (last) begin
      valid_d = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        freq_d[i*CNT_W +: CNT_W] = sat_inc(acc_q[i], ev[i]);
        ovf_d[i]                 = iovf_q[i] | sat_hit(acc_q[i], ev[i]);
      end
    end else if (run) begin
      gcnt_d = gcnt_q + GW'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        acc_d[i]  = sat_inc(acc_q[i], ev[i]);
        iovf_d[i] = iovf_q[i] | sat_hit(acc_q[i], ev[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      mode_q  <= '0;
      gcnt_q  <= '0;
      iovf_q  <= '0;
      freq_q  <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      sync1_q <= infreq;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      mode_q  <= mode;
      gcnt_q  <= gcnt_d;
      iovf_q  <= iovf_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= en;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign freq  = freq_q;
  assign ovf   = ovf_q;
  assign valid = valid_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_multi_freq_meter.sv
// Self-checking bench for multi_freq_meter: directed scenarios plus random
// waveforms checked against a sample-based edge-count model.
module tb_multi_freq_meter;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int CWS = 4;
  localparam int G   = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [1:0] mode;
  logic [NCH-1:0] infreq = '0;
  logic [NCH*CW-1:0]  freq;
  logic [NCH*CWS-1:0] freq_s;
  logic [NCH-1:0] ovf, ovf_s;
  logic valid, valid_s, busy, busy_s;

  int total = 0;
  int bad   = 0;

  int gen_kind [NCH] = '{default: 0};
  int half     [NCH] = '{default: 1};
  int cnt      [NCH] = '{default: 0};
  logic [NCH-1:0] man = '0;

  multi_freq_meter #(.NUM_CH(NCH), .CNT_W(CW), .GATE_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .infreq(infreq),
    .freq(freq), .ovf(ovf), .valid(valid), .busy(busy));

  multi_freq_meter #(.NUM_CH(NCH), .CNT_W(CWS), .GATE_CYCLES(G)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .infreq(infreq),
    .freq(freq_s), .ovf(ovf_s), .valid(valid_s), .busy(busy_s));

  always #5 clk = ~clk;

  // Waveform generator: 0 = manual level, 1 = periodic (half period), 2 = random runs of 2..6.
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        case (gen_kind[c])
          1: begin
            cnt[c]++;
            if (cnt[c] >= half[c]) begin cnt[c] = 0; infreq[c] = ~infreq[c]; end
          end
          2: begin
            cnt[c]--;
            if (cnt[c] <= 0) begin cnt[c] = $urandom_range(2, 6); infreq[c] = ~infreq[c]; end
          end
          default: infreq[c] = man[c];
        endcase
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int lim, output int n, output bit got);
    n = 0; got = 1'b0;
    while (!got && n < lim) begin
      tick(); n++;
      if (valid) got = 1'b1;
    end
  endtask

  task automatic set_periodic(input int c, input int h);
    gen_kind[c] = 1; half[c] = h; cnt[c] = 0;
  endtask

  function automatic int fld(input logic [NCH*CW-1:0] v, input int c);
    return int'(v[c*CW +: CW]);
  endfunction

  function automatic int fld_s(input logic [NCH*CWS-1:0] v, input int c);
    return int'(v[c*CWS +: CWS]);
  endfunction

  function automatic int edge_hit(input int m, input logic o, input logic nw);
    if (m == 1) return (o && !nw) ? 1 : 0;
    if (m == 2) return (o != nw) ? 1 : 0;
    return (!o && nw) ? 1 : 0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; man = '0;
    repeat (3) tick();
    total++; if (freq !== '0) begin bad++; $display("FAIL reset_freq got=%h want=0", freq); end
    total++; if (ovf !== '0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    total++; if (valid !== 1'b0 || valid_s !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b/%b want=0", valid, valid_s); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (freq_s !== '0 || ovf_s !== '0) begin bad++; $display("FAIL reset_small got=%h/%b want=0", freq_s, ovf_s); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) tick();
    total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_disabled valid=%b busy=%b want 0/0", valid, busy); end
  endtask

  task automatic test_basic();
    int n; bit got;
    int exp_f [NCH] = '{10, 25, 0, 2};
    int exp_s [NCH] = '{10, 15, 0, 2};
    set_periodic(0, 5); set_periodic(1, 2); gen_kind[2] = 0; man[2] = 1'b1; set_periodic(3, 25);
    en = 1'b1;
    tick(); tick();
    total++; if (busy !== 1'b1 || busy_s !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    wait_valid(150, n, got);
    total++; if (!got) begin bad++; $display("FAIL basic_first_valid got none within %0d cycles", n); end
    for (int w = 0; w < 2; w++) begin
      wait_valid(200, n, got);
      total++; if (!got || n != G) begin bad++; $display("FAIL basic_period got=%0d want=%0d", n, G); end
      for (int c = 0; c < NCH; c++) begin
        total++; if (fld(freq, c) != exp_f[c]) begin bad++; $display("FAIL basic_freq ch%0d got=%0d want=%0d", c, fld(freq, c), exp_f[c]); end
        total++; if (fld_s(freq_s, c) != exp_s[c]) begin bad++; $display("FAIL basic_freq_small ch%0d got=%0d want=%0d", c, fld_s(freq_s, c), exp_s[c]); end
      end
      total++; if (ovf !== 4'b0000 || ovf_s !== 4'b0010) begin bad++; $display("FAIL basic_ovf got=%b/%b want=0000/0010", ovf, ovf_s); end
    end
  endtask

  task automatic test_saturation();
    int n; bit got;
    set_periodic(0, 2);
    wait_valid(200, n, got);
    wait_valid(200, n, got);
    total++; if (!got || fld_s(freq_s, 0) != 15 || ovf_s[0] !== 1'b1) begin bad++; $display("FAIL sat_small got=%0d ovf=%b want=15 ovf=1", fld_s(freq_s, 0), ovf_s[0]); end
    total++; if (fld(freq, 0) != 25 || ovf[0] !== 1'b0) begin bad++; $display("FAIL sat_wide got=%0d ovf=%b want=25 ovf=0", fld(freq, 0), ovf[0]); end
    set_periodic(0, 5);
    wait_valid(200, n, got);
    wait_valid(200, n, got);
    total++; if (!got || fld_s(freq_s, 0) != 10 || ovf_s[0] !== 1'b0) begin bad++; $display("FAIL sat_recover got=%0d ovf=%b want=10 ovf=0", fld_s(freq_s, 0), ovf_s[0]); end
  endtask

  task automatic test_modes();
    int n; bit got; int d;
    int mseq [3] = '{1, 2, 0};
    int e0 [3] = '{10, 20, 10};
    int e1 [3] = '{25, 50, 25};
    for (int i = 0; i < 3; i++) begin
      wait_valid(200, n, got);
      d = (i == 1) ? 99 : $urandom_range(5, 90);
      repeat (d) tick();
      mode = 2'(mseq[i]);
      wait_valid(250, n, got);
      total++; if (!got || n != G + 1) begin bad++; $display("FAIL mode_discard m=%0d got=%0d want=%0d", mseq[i], n, G + 1); end
      total++; if (fld(freq, 0) != e0[i] || fld(freq, 1) != e1[i]) begin bad++; $display("FAIL mode_count m=%0d got=%0d,%0d want=%0d,%0d", mseq[i], fld(freq, 0), fld(freq, 1), e0[i], e1[i]); end
      wait_valid(200, n, got);
      total++; if (!got || n != G || fld(freq, 0) != e0[i]) begin bad++; $display("FAIL mode_steady m=%0d period=%0d count=%0d want %0d/%0d", mseq[i], n, fld(freq, 0), G, e0[i]); end
    end
  endtask

  task automatic test_enable_abort();
    int n; bit got; int nv;
    logic [NCH*CW-1:0] save;
    int exp_f [NCH] = '{10, 25, 0, 2};
    wait_valid(200, n, got);
    save = freq;
    repeat (50) tick();
    en = 1'b0;
    nv = 0;
    repeat (20) begin tick(); if (valid) nv++; end
    total++; if (nv != 0) begin bad++; $display("FAIL abort_valid got=%0d strobes want=0", nv); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (freq !== save) begin bad++; $display("FAIL abort_hold got=%h want=%h", freq, save); end
    en = 1'b1;
    wait_valid(250, n, got);
    total++; if (!got || n + 1 != 101) begin bad++; $display("FAIL abort_reenable_latency got=%0d want=101", n + 1); end
    for (int c = 0; c < NCH; c++) begin
      total++; if (fld(freq, c) != exp_f[c]) begin bad++; $display("FAIL abort_count ch%0d got=%0d want=%0d", c, fld(freq, c), exp_f[c]); end
    end
  endtask

  task automatic test_boundary();
    int n; bit got;
    gen_kind[0] = 0; gen_kind[1] = 0; man[0] = 1'b0; man[1] = 1'b0;
    wait_valid(200, n, got);
    wait_valid(200, n, got);
    repeat (97) tick();
    man[0] = 1'b1;
    tick();
    man[1] = 1'b1;
    wait_valid(200, n, got);
    total++; if (!got || n != 2) begin bad++; $display("FAIL boundary_timing got=%0d want=2", n); end
    total++; if (fld(freq, 0) != 1 || fld(freq, 1) != 0) begin bad++; $display("FAIL boundary_last got=%0d,%0d want=1,0", fld(freq, 0), fld(freq, 1)); end
    wait_valid(200, n, got);
    total++; if (!got || fld(freq, 0) != 0 || fld(freq, 1) != 1) begin bad++; $display("FAIL boundary_first got=%0d,%0d want=0,1", fld(freq, 0), fld(freq, 1)); end
  endtask

  task automatic test_async_reset();
    int n; bit got;
    wait_valid(200, n, got);
    repeat (30) tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (freq !== '0) begin bad++; $display("FAIL areset_freq got=%h want=0", freq); end
    total++; if (ovf !== '0 || ovf_s !== '0) begin bad++; $display("FAIL areset_ovf got=%b/%b want=0", ovf, ovf_s); end
    total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL areset_busy busy=%b valid=%b want=0", busy, valid); end
    total++; if (freq_s !== '0) begin bad++; $display("FAIL areset_freq_small got=%h want=0", freq_s); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    wait_valid(250, n, got);
    total++; if (!got || n + 1 != 101) begin bad++; $display("FAIL areset_first_valid got=%0d want=101", n + 1); end
    total++; if (fld(freq, 0) != 1 || fld(freq, 1) != 1 || fld(freq, 2) != 1) begin bad++; $display("FAIL areset_static got=%0d,%0d,%0d want=1,1,1", fld(freq, 0), fld(freq, 1), fld(freq, 2)); end
  endtask

  task automatic test_random();
    int mseq [4] = '{3, 0, 1, 2};
    logic [NCH-1:0] s [$];
    int k, prev, nval, ec, es;
    for (int mi = 0; mi < 4; mi++) begin
      mode = 2'(mseq[mi]);
      for (int c = 0; c < NCH; c++) begin gen_kind[c] = 2; cnt[c] = 3; end
      s.delete(); prev = -1; nval = 0;
      for (int cyc = 0; cyc < 450; cyc++) begin
        tick();
        s.push_back(infreq);
        if (valid) begin
          k = s.size() - 1;
          nval++;
          total++;
          if ((prev < 0 && k != G) || (prev >= 0 && k - prev != G)) begin
            bad++; $display("FAIL random_period m=%0d at=%0d prev=%0d want spacing %0d", mseq[mi], k, prev, G);
          end
          prev = k;
          if (k >= G + 2) begin
            for (int c = 0; c < NCH; c++) begin
              ec = 0;
              for (int j = k - G + 1; j <= k; j++) ec += edge_hit(mseq[mi], s[j-3][c], s[j-2][c]);
              es = (ec > 15) ? 15 : ec;
              total++; if (fld(freq, c) != ec || ovf[c] !== 1'b0) begin bad++; $display("FAIL random_count m=%0d ch%0d got=%0d ovf=%b want=%0d ovf=0", mseq[mi], c, fld(freq, c), ovf[c], ec); end
              total++; if (fld_s(freq_s, c) != es || ovf_s[c] !== (ec > 15)) begin bad++; $display("FAIL random_sat m=%0d ch%0d got=%0d ovf=%b want=%0d ovf=%0d", mseq[mi], c, fld_s(freq_s, c), ovf_s[c], es, (ec > 15)); end
            end
          end
        end
      end
      total++; if (nval != 4) begin bad++; $display("FAIL random_valid_count m=%0d got=%0d want=4", mseq[mi], nval); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_modes();
    test_enable_abort();
    test_boundary();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
